// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver; optional error-frame dropping under UART_RX_DROP_ERR_EN.
// Latency: push visible on out_* one cycle later (FWFT). Backpressure: none upstream; full FIFO drops and flags overrun.
module uart_rx_fifo #(
   parameter int DATA_BITS = 8,
   parameter int DEPTH     = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DATA_BITS-1:0]     rx_data,
   input  logic                     rx_done,
   input  logic                     rx_error,
   output logic [DATA_BITS-1:0]     out_data,
   output logic                     out_err,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     overrun,
   input  logic                     clr_overrun,
   output logic [7:0]               err_drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_BITS:0]  mem_q [DEPTH];
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       count_q, count_d;
   logic                overrun_q, overrun_d;
   logic                wr_req, push, pop, ovr_evt;
   logic [DATA_BITS:0]  head;

   assign empty     = (count_q == '0);
   assign full      = (count_q == CW'(DEPTH));
   assign out_valid = ~empty;
   assign count     = count_q;
   assign overrun   = overrun_q;
   assign pop       = out_valid & out_ready;

`ifdef UART_RX_DROP_ERR_EN
   logic [7:0] err_drop_cnt_q, err_drop_cnt_d;
   logic       drop_evt;

   assign drop_evt     = rx_done & rx_error;
   assign wr_req       = rx_done & ~rx_error;
   assign err_drop_cnt = err_drop_cnt_q;

   always_comb begin
      err_drop_cnt_d = err_drop_cnt_q;
      if (drop_evt && (err_drop_cnt_q != 8'hFF))
         err_drop_cnt_d = err_drop_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_drop_cnt_q <= 8'd0;
      else        err_drop_cnt_q <= err_drop_cnt_d;
   end
`else
   assign wr_req       = rx_done;
   assign err_drop_cnt = 8'd0;
`endif

   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign push    = wr_req & (~full | pop);
   assign ovr_evt = wr_req & full & ~pop;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      overrun_d = overrun_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
      if (clr_overrun) overrun_d = 1'b0;
      if (ovr_evt)     overrun_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         overrun_q <= overrun_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {rx_error, rx_data};
   end

   assign head     = mem_q[rd_ptr_q];
   assign out_data = out_valid ? head[DATA_BITS-1:0] : '0;
   assign out_err  = out_valid & head[DATA_BITS];

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

   localparam int DB    = 8;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DB-1:0] rx_data = '0;
   logic          rx_done = 1'b0;
   logic          rx_error = 1'b0;
   logic [DB-1:0] out_data;
   logic          out_err;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;
   logic          overrun;
   logic          clr_overrun = 1'b0;
   logic [7:0]    err_drop_cnt;

   uart_rx_fifo #(.DATA_BITS(DB), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
      .rx_error(rx_error), .out_data(out_data), .out_err(out_err),
      .out_valid(out_valid), .out_ready(out_ready), .count(count),
      .full(full), .empty(empty), .overrun(overrun),
      .clr_overrun(clr_overrun), .err_drop_cnt(err_drop_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: ordered list of {err,data}, sticky flag, drop counter.
   logic [DB:0] mq[$];
   logic        m_ovr = 1'b0;
   int          m_drop = 0;

`ifdef UART_RX_DROP_ERR_EN
   localparam bit DROP_EN = 1'b1;
`else
   localparam bit DROP_EN = 1'b0;
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_ovr  = 1'b0;
      m_drop = 0;
   endtask

   task automatic model_cycle(input logic d, input logic [DB-1:0] dat, input logic e,
                              input logic rdy, input logic clr);
      bit was_full, do_pop, dropped, wants;
      was_full = (mq.size() == DEPTH);
      do_pop   = (mq.size() != 0) && rdy;
      dropped  = DROP_EN && d && e;
      wants    = d && !dropped;
      if (do_pop) void'(mq.pop_front());
      if (wants && (!was_full || do_pop)) mq.push_back({e, dat});
      if (clr) m_ovr = 1'b0;
      if (wants && was_full && !do_pop) m_ovr = 1'b1;
      if (dropped && m_drop < 255) m_drop++;
   endtask

   task automatic check_all(input string tag);
      logic [DB:0] h;
      h = (mq.size() != 0) ? mq[0] : '0;
      chk({tag, ".valid"}, 32'(out_valid), 32'(mq.size() != 0));
      chk({tag, ".data"},  32'(out_data),  32'(h[DB-1:0]));
      chk({tag, ".err"},   32'(out_err),   32'(h[DB]));
      chk({tag, ".count"}, 32'(count),     32'(mq.size()));
      chk({tag, ".full"},  32'(full),      32'(mq.size() == DEPTH));
      chk({tag, ".empty"}, 32'(empty),     32'(mq.size() == 0));
      chk({tag, ".ovr"},   32'(overrun),   32'(m_ovr));
      chk({tag, ".drop"},  32'(err_drop_cnt), 32'(m_drop));
   endtask

   task automatic step(input string tag, input logic d, input logic [DB-1:0] dat,
                       input logic e, input logic rdy, input logic clr);
      rx_done = d; rx_data = dat; rx_error = e; out_ready = rdy; clr_overrun = clr;
      @(posedge clk);
      model_cycle(d, dat, e, rdy, clr);
      #1;
      rx_done = 1'b0; rx_error = 1'b0; clr_overrun = 1'b0;
      check_all(tag);
   endtask

   initial begin
      logic [DB-1:0] exp_seq [4];
      logic [DB-1:0] got;

      // Reset state
      #2;
      check_all("reset");
      chk("reset.empty_const", 32'(empty), 32'd1);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      // Three pushes with consumer stalled, then drain back-to-back
      step("tp1.push", 1, 8'h41, 0, 0, 0);
      step("tp1.push", 1, 8'h42, 0, 0, 0);
      step("tp1.push", 1, 8'h43, 0, 0, 0);
      chk("tp1.count3", 32'(count), 32'd3);
      chk("tp1.head41", 32'(out_data), 32'h41);
      step("tp1.stall", 0, 8'h00, 0, 0, 0);
      chk("tp1.stable", 32'(out_data), 32'h41);
      exp_seq = '{8'h41, 8'h42, 8'h43, 8'h00};
      for (int i = 0; i < 3; i++) begin
         chk("tp1.order", 32'(out_data), 32'(exp_seq[i]));
         step("tp1.pop", 0, 8'h00, 0, 1, 0);
      end
      chk("tp1.empty", 32'(empty), 32'd1);
      chk("tp1.novalid", 32'(out_valid), 32'd0);

      // Overfill: fifth character lost, overrun sticky until cleared
      for (int i = 0; i < 5; i++) step("tp2.fill", 1, 8'(8'h10 + i), 0, 0, 0);
      chk("tp2.full", 32'(full), 32'd1);
      chk("tp2.count4", 32'(count), 32'd4);
      chk("tp2.ovr", 32'(overrun), 32'd1);
      step("tp2.clr", 0, 8'h00, 0, 0, 1);
      chk("tp2.ovr_clr", 32'(overrun), 32'd0);

      // Full + write + pop in the same cycle
      chk("tp3.head10", 32'(out_data), 32'h10);
      step("tp3.pushpop", 1, 8'h55, 0, 1, 0);
      chk("tp3.count4", 32'(count), 32'd4);
      chk("tp3.noovr", 32'(overrun), 32'd0);
      exp_seq = '{8'h11, 8'h12, 8'h13, 8'h55};
      for (int i = 0; i < 4; i++) begin
         got = out_data;
         chk("tp3.drain", 32'(got), 32'(exp_seq[i]));
         step("tp3.pop", 0, 8'h00, 0, 1, 0);
      end
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < DEPTH; i++) step("wrap.fill", 1, 8'($urandom), 0, 0, 0);
         for (int i = 0; i < DEPTH; i++) step("wrap.drain", 0, 8'h00, 0, 1, 0);
      end

      // Set and clear of overrun in the same cycle: set wins
      for (int i = 0; i < DEPTH; i++) step("sw.fill", 1, 8'(i), 0, 0, 0);
      step("sw.both", 1, 8'hEE, 0, 0, 1);
      chk("sw.ovr", 32'(overrun), 32'd1);
      step("sw.clr", 0, 8'h00, 0, 0, 1);
      for (int i = 0; i < DEPTH; i++) step("sw.drain", 0, 8'h00, 0, 1, 0);

      // Error frame
      step("tp4.err", 1, 8'h7E, 1, 0, 0);
      if (DROP_EN) begin
         chk("tp4.dropped_empty", 32'(empty), 32'd1);
         chk("tp4.drop_cnt", 32'(err_drop_cnt), 32'd1);
      end else begin
         chk("tp4.data", 32'(out_data), 32'h7E);
         chk("tp4.err_flag", 32'(out_err), 32'd1);
      end
      step("tp4.stray_err", 0, 8'h00, 1, 1, 0);
      step("tp4.drain", 0, 8'h00, 0, 1, 0);

      // Push into empty FIFO with consumer always ready
      step("tp5.push", 1, 8'hA5, 0, 1, 0);
      chk("tp5.valid", 32'(out_valid), 32'd1);
      chk("tp5.data", 32'(out_data), 32'hA5);
      step("tp5.pop", 0, 8'h00, 0, 1, 0);
      chk("tp5.gone", 32'(out_valid), 32'd0);
      step("tp5.idle", 0, 8'h00, 0, 1, 0);
      chk("tp5.nounder", 32'(count), 32'd0);

      // Asynchronous reset between edges
      for (int i = 0; i < 5; i++) step("tp6.fill", 1, 8'(8'h60 + i), 0, 0, 0);
      step("tp6.pop", 0, 8'h00, 0, 1, 0);
      chk("tp6.pre_count", 32'(count), 32'd3);
      chk("tp6.pre_ovr", 32'(overrun), 32'd1);
      out_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("tp6.count0", 32'(count), 32'd0);
      chk("tp6.empty", 32'(empty), 32'd1);
      chk("tp6.ovr0", 32'(overrun), 32'd0);
      chk("tp6.valid0", 32'(out_valid), 32'd0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      check_all("tp6.post");

      // Randomized traffic: fill-biased phase then drain-biased phase
      for (int i = 0; i < 600; i++) begin
         logic d, e, rdy, clr;
         d   = ($urandom_range(0, 99) < 55);
         e   = ($urandom_range(0, 99) < 20);
         rdy = (i < 300) ? ($urandom_range(0, 99) < 25) : ($urandom_range(0, 99) < 75);
         clr = ($urandom_range(0, 99) < 5);
         step("rand", d, 8'($urandom), e, rdy, clr);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer directly downstream of the UART receiver.
- Captures each received character (rx_data qualified by the one-cycle rx_done pulse) together with its rx_error status into a FIFO.
- Presents characters to the register/bus side via a valid/ready handshake.
- Flags overrun when the receiver delivers a character while the buffer is full.

Parameters:
DATA_BITS, 8, width of a received character (matches receiver rx_data).
DEPTH, 16, FIFO entries; power of 2, minimum 2.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
rx_data  input  DATA_BITS  character from receiver; valid only when rx_done=1.
rx_done  input  1  one-clk-cycle pulse: character ready (write event).
rx_error  input  1  error flag for the character; sampled only in the rx_done cycle.
out_data  output  DATA_BITS  head-of-FIFO character.
out_err  output  1  error flag stored with the head character.
out_valid  output  1  FIFO not empty; out_data/out_err are valid.
out_ready  input  1  consumer accepts the head entry.
count  output  $clog2(DEPTH)+1  current number of stored entries.
full  output  1  count==DEPTH.
empty  output  1  count==0.
overrun  output  1  sticky: a character was lost because the FIFO was full.
clr_overrun  input  1  synchronous clear of overrun.
err_drop_cnt  output  8  dropped error-frame count (feature only; otherwise tied 0).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - write/read pointers=0, count=0, empty=1, full=0, out_valid=0, overrun=0, err_drop_cnt=0.
  - out_data=0 and out_err=0 while empty.
  - Memory contents are not reset.
- Reset mid-operation discards all entries immediately. A character whose rx_done pulse coincides with reset is lost.
- Storage: DEPTH x (DATA_BITS+1) array holding {err, data}. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Push: rx_done=1 and (not full, or pop in the same cycle). Writes {rx_error, rx_data} at wr_ptr; wr_ptr+1.
- Pop: out_valid=1 and out_ready=1. rd_ptr+1.
- Output is first-word-fall-through, driven from mem[rd_ptr]:
  - Push at edge N into an empty FIFO -> out_valid=1 and data visible after edge N (latency 1 cycle).
  - Consumer may hold out_ready=1 continuously; 1 entry per cycle throughput.
  - out_data/out_err stay stable while out_valid=1 and out_ready=0.
- count: +1 on push only, -1 on pop only, unchanged on push+pop or neither. Never exceeds DEPTH and never underflows.
- Full + rx_done + pop in the same cycle: both happen; count stays DEPTH; no overrun.
- Full + rx_done, no pop: character discarded; pointers and count unchanged; overrun set to 1 on the next edge.
- Empty: out_ready is ignored (no pop). Push on an empty FIFO is unaffected by out_ready.
- overrun: sticky until clr_overrun=1. If clr_overrun and a new overrun event occur in the same cycle, overrun stays 1 (set wins).
- rx_error with rx_done=0 is ignored.
- No internal state machine beyond the pointers/counters. All outputs are registered or decoded directly from registered state.

Optional Feature:
Macro UART_RX_DROP_ERR_EN.
- Defined:
  - A character with rx_error=1 in its rx_done cycle is not written to the FIFO.
  - err_drop_cnt increments by 1 on each such drop and saturates at 255. It is cleared only by reset.
  - A dropped error frame never causes overrun, even when the FIFO is full.
  - out_err is always 0.
- Not defined: error frames are stored normally with out_err=1, and err_drop_cnt is constant 0.

Test Plan:
- Reset then push 0x41, 0x42, 0x43 with out_ready=0 -> count=3, out_valid=1, out_data=0x41; then out_ready=1 for 3 cycles -> 0x41, 0x42, 0x43 in consecutive cycles, then empty=1, out_valid=0.
- DEPTH=4: push 5 chars 0x10..0x14 with no pop -> full=1, count=4, overrun=1; pop all -> 0x10..0x13 (0x14 lost); pulse clr_overrun -> overrun=0.
- Full FIFO, rx_done=1 with 0x55 in the same cycle as a pop -> count remains 4, overrun=0, 0x55 read out last; wrap-around verified by 3 further fill/drain cycles.
- Push 0x7E with rx_error=1 -> without the macro: out_data=0x7E, out_err=1; with UART_RX_DROP_ERR_EN: FIFO stays empty, err_drop_cnt=1.
- Empty FIFO, push 0xA5 with out_ready held 1 -> out_valid high exactly one cycle, one pop, count returns to 0, no underflow.
- Assert rst_n=0 asynchronously (between edges) with count=3 and overrun=1 -> count=0, empty=1, overrun=0, out_valid=0 immediately, before the next clk edge.
